// File: rtl/bloom_pkg.sv
// Shared definitions for the counting-Bloom-filter SRAM controller:
// one-hot FSM encoding, SRAM direction encoding and counter ceiling helper.
package bloom_pkg;

    typedef enum logic [8:0] {
        ST_IDLE     = 9'b0_0000_0001,
        ST_RD0      = 9'b0_0000_0010,
        ST_RD0_WAIT = 9'b0_0000_0100,
        ST_RD1      = 9'b0_0000_1000,
        ST_RD1_WAIT = 9'b0_0001_0000,
        ST_DECIDE   = 9'b0_0010_0000,
        ST_WR0      = 9'b0_0100_0000,
        ST_WR1      = 9'b0_1000_0000,
        ST_DONE     = 9'b1_0000_0000
    } state_e;

    localparam logic SRAM_RD = 1'b1;
    localparam logic SRAM_WR = 1'b0;

    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/bloom_cnt_update.sv
// Combinational counting-Bloom counter step: +1 on insert, -1 on ACK hit,
// with a sticky ceiling at CNT_MAX.
module bloom_cnt_update
    import bloom_pkg::*;
#(
    parameter int CNT_WIDTH = 4
) (
    input  logic [CNT_WIDTH-1:0] c,
    input  logic                 is_ack,
    output logic [CNT_WIDTH-1:0] new_c,
    output logic                 sat
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

    // A saturated counter has lost its true count, so it is never decremented.
    function automatic logic [CNT_WIDTH-1:0] step_cnt(input logic [CNT_WIDTH-1:0] v,
                                                      input logic                 dec);
        if (v == CNT_MAX) begin
            return CNT_MAX;
        end else if (dec) begin
            return v - CNT_WIDTH'(1);
        end else begin
            return v + CNT_WIDTH'(1);
        end
    endfunction

    always_comb begin
        new_c = step_cnt(c, is_ack);
        sat   = (new_c == CNT_MAX);
    end

endmodule

// File: rtl/bloom_sram_ctrl.sv
// Read-modify-write sequencer for the counting-Bloom-filter SRAM.
// Optional statistics counters enabled by `define BLOOM_SRAM_CTRL_STATS_EN.
module bloom_sram_ctrl
    import bloom_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 36,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bloom_wr,
    output logic                       bloom_rdy,
    input  logic [SRAM_ADDR_WIDTH-1:0] index_0,
    input  logic [SRAM_ADDR_WIDTH-1:0] index_1,
    input  logic                       pkt_is_ack,
    output logic                       lookup_vld,
    output logic                       lookup_hit,
    output logic                       sram_req,
    output logic                       sram_rd_wr_L,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    input  logic                       sram_ack,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
    input  logic                       sram_rd_vld,
    output logic [31:0]                stat_insert,
    output logic [31:0]                stat_hit,
    output logic [31:0]                stat_miss,
    output logic [31:0]                stat_sat
);

    state_e                     state_q, state_d;
    logic [SRAM_ADDR_WIDTH-1:0] idx0_q, idx0_d;
    logic [SRAM_ADDR_WIDTH-1:0] idx1_q, idx1_d;
    logic                       is_ack_q, is_ack_d;
    logic                       same_q, same_d;
    logic                       hit_q, hit_d;
    logic [CNT_WIDTH-1:0]       c0_q, c0_d;
    logic [CNT_WIDTH-1:0]       c1_q, c1_d;
    logic [CNT_WIDTH-1:0]       new0, new1;
    logic                       sat0, sat1;
    logic [CNT_WIDTH-1:0]       rd_cnt;
    logic                       unused_rd_hi;

    assign rd_cnt       = sram_rd_data[CNT_WIDTH-1:0];
    assign unused_rd_hi = ^sram_rd_data[SRAM_DATA_WIDTH-1:CNT_WIDTH];

    bloom_cnt_update #(.CNT_WIDTH(CNT_WIDTH)) u_upd0 (
        .c      (c0_q),
        .is_ack (is_ack_q),
        .new_c  (new0),
        .sat    (sat0)
    );

    bloom_cnt_update #(.CNT_WIDTH(CNT_WIDTH)) u_upd1 (
        .c      (c1_q),
        .is_ack (is_ack_q),
        .new_c  (new1),
        .sat    (sat1)
    );

    always_comb begin
        state_d  = state_q;
        idx0_d   = idx0_q;
        idx1_d   = idx1_q;
        is_ack_d = is_ack_q;
        same_d   = same_q;
        hit_d    = hit_q;
        c0_d     = c0_q;
        c1_d     = c1_q;
        case (state_q)
            ST_IDLE: begin
                if (bloom_wr) begin
                    idx0_d   = index_0;
                    idx1_d   = index_1;
                    is_ack_d = pkt_is_ack;
                    same_d   = (index_0 == index_1);
                    state_d  = ST_RD0;
                end
            end
            ST_RD0: begin
                if (sram_ack) state_d = ST_RD0_WAIT;
            end
            // c1 mirrors c0 here so equal indices need no second read.
            ST_RD0_WAIT: begin
                if (sram_rd_vld) begin
                    c0_d    = rd_cnt;
                    c1_d    = rd_cnt;
                    state_d = same_q ? ST_DECIDE : ST_RD1;
                end
            end
            ST_RD1: begin
                if (sram_ack) state_d = ST_RD1_WAIT;
            end
            ST_RD1_WAIT: begin
                if (sram_rd_vld) begin
                    c1_d    = rd_cnt;
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                hit_d   = (c0_q != '0) && (c1_q != '0);
                state_d = (!is_ack_q || hit_d) ? ST_WR0 : ST_DONE;
            end
            ST_WR0: begin
                if (sram_ack) state_d = same_q ? ST_DONE : ST_WR1;
            end
            ST_WR1: begin
                if (sram_ack) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bloom_rdy    = (state_q == ST_IDLE);
        sram_req     = 1'b0;
        sram_rd_wr_L = SRAM_RD;
        sram_addr    = '0;
        sram_wr_data = '0;
        case (state_q)
            ST_RD0: begin
                sram_req  = 1'b1;
                sram_addr = idx0_q;
            end
            ST_RD1: begin
                sram_req  = 1'b1;
                sram_addr = idx1_q;
            end
            ST_WR0: begin
                sram_req     = 1'b1;
                sram_rd_wr_L = SRAM_WR;
                sram_addr    = idx0_q;
                sram_wr_data = SRAM_DATA_WIDTH'(new0);
            end
            ST_WR1: begin
                sram_req     = 1'b1;
                sram_rd_wr_L = SRAM_WR;
                sram_addr    = idx1_q;
                sram_wr_data = SRAM_DATA_WIDTH'(new1);
            end
            default: begin
            end
        endcase
        lookup_vld = (state_q == ST_DONE) && is_ack_q;
        lookup_hit = lookup_vld && hit_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
        idx0_q   <= idx0_d;
        idx1_q   <= idx1_d;
        is_ack_q <= is_ack_d;
        same_q   <= same_d;
        hit_q    <= hit_d;
        c0_q     <= c0_d;
        c1_q     <= c1_d;
    end

`ifdef BLOOM_SRAM_CTRL_STATS_EN
    logic [31:0] stat_insert_q, stat_insert_d;
    logic [31:0] stat_hit_q, stat_hit_d;
    logic [31:0] stat_miss_q, stat_miss_d;
    logic [31:0] stat_sat_q, stat_sat_d;

    always_comb begin
        stat_insert_d = stat_insert_q;
        stat_hit_d    = stat_hit_q;
        stat_miss_d   = stat_miss_q;
        stat_sat_d    = stat_sat_q;
        if (state_q == ST_DONE) begin
            if (!is_ack_q) begin
                stat_insert_d = stat_insert_q + 32'd1;
            end else if (hit_q) begin
                stat_hit_d = stat_hit_q + 32'd1;
            end else begin
                stat_miss_d = stat_miss_q + 32'd1;
            end
            // Only transactions that reached the write phase count saturations.
            if (!is_ack_q || hit_q) begin
                stat_sat_d = stat_sat_q + 32'(sat0) + 32'(sat1 && !same_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_insert_q <= '0;
            stat_hit_q    <= '0;
            stat_miss_q   <= '0;
            stat_sat_q    <= '0;
        end else begin
            stat_insert_q <= stat_insert_d;
            stat_hit_q    <= stat_hit_d;
            stat_miss_q   <= stat_miss_d;
            stat_sat_q    <= stat_sat_d;
        end
    end

    assign stat_insert = stat_insert_q;
    assign stat_hit    = stat_hit_q;
    assign stat_miss   = stat_miss_q;
    assign stat_sat    = stat_sat_q;
`else
    logic unused_sat;

    assign unused_sat  = sat0 ^ sat1;
    assign stat_insert = '0;
    assign stat_hit    = '0;
    assign stat_miss   = '0;
    assign stat_sat    = '0;
`endif

endmodule

// File: doc/bloom_sram_ctrl.md
Name: bloom_sram_ctrl

Overview:
- Controller that sequences the counting-Bloom-filter SRAM on behalf of the TCP tuple parser.
- It accepts one hashed request at a time: two indices plus an insert/ack flag. It then performs the read-modify-write of the two SRAM counters and reports hit/miss for ACK lookups.
- It sits between the parser's bloom handshake (bloom_wr/bloom_rdy) and the single-port SRAM arbiter.

Parameters:
- SRAM_ADDR_WIDTH, 19, SRAM word address width; equals the hash index width.
- SRAM_DATA_WIDTH, 36, SRAM word width.
- CNT_WIDTH, 4, counter bits held in sram data [CNT_WIDTH-1:0]; upper bits are written 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- bloom_wr  in  1  request strobe, valid only while bloom_rdy=1
- bloom_rdy  out  1  controller idle, can accept a request
- index_0  in  SRAM_ADDR_WIDTH  first hash index
- index_1  in  SRAM_ADDR_WIDTH  second hash index
- pkt_is_ack  in  1  1 = lookup/remove (ACK), 0 = insert (expected ack)
- lookup_vld  out  1  one-cycle pulse, ACK lookup finished
- lookup_hit  out  1  valid with lookup_vld: both counters were nonzero
- sram_req  out  1  SRAM access request, held until sram_ack
- sram_rd_wr_L  out  1  1 = read, 0 = write
- sram_addr  out  SRAM_ADDR_WIDTH  access address
- sram_wr_data  out  SRAM_DATA_WIDTH  write data
- sram_ack  in  1  arbiter grant; access consumed this cycle
- sram_rd_data  in  SRAM_DATA_WIDTH  read return data
- sram_rd_vld  in  1  read data valid, arrives 1 or more cycles after a read's sram_ack
- stat_insert, stat_hit, stat_miss, stat_sat  out  32 each  statistics (see Optional Feature)

Behaviour:
- Reset values: state IDLE, bloom_rdy=1, sram_req=0, sram_rd_wr_L=1, sram_addr=0, sram_wr_data=0, lookup_vld=0, lookup_hit=0, stats=0.
- Request capture:
  - bloom_rdy=1 only in IDLE.
  - bloom_wr && bloom_rdy latches index_0, index_1, pkt_is_ack and a flag same = (index_0==index_1).
  - bloom_rdy drops the next cycle.
  - bloom_wr while bloom_rdy=0 is ignored.
- States: IDLE, RD0, RD0_WAIT, RD1, RD1_WAIT, DECIDE, WR0, WR1, DONE.
  - RD0: sram_req=1, read addr i0. On sram_ack go to RD0_WAIT.
  - RD0_WAIT: on sram_rd_vld latch c0; go to DECIDE if same, else RD1.
  - RD1/RD1_WAIT: as above for i1, latching c1; then DECIDE.
  - DECIDE (one cycle):
    - Insert: go to WR0.
    - ACK: hit = (c0!=0)&&(c1!=0), using c1=c0 when same. Hit goes to WR0; miss goes to DONE with no writes.
  - WR0: write new(c0) to i0. On sram_ack go to DONE if same, else WR1.
  - WR1: write new(c1) to i1. On sram_ack go to DONE.
  - DONE: if ACK, pulse lookup_vld with lookup_hit. Go to IDLE, where bloom_rdy=1 the following cycle.
- Counter update, with CNT_MAX = 2^CNT_WIDTH-1:
  - Insert: new = (c==CNT_MAX) ? CNT_MAX : c+1.
  - ACK hit: new = (c==CNT_MAX) ? CNT_MAX : c-1. Saturated counters are sticky and never decremented.
  - Equal indices: exactly one read and one write, applying a single +1/-1.
- Minimum latency with sram_ack and sram_rd_vld each after 1 cycle:
  - Distinct-index insert: about 9 cycles accept-to-bloom_rdy.
  - ACK miss: no SRAM writes.
- SRAM rules:
  - At most one outstanding access.
  - sram_addr, sram_rd_wr_L and sram_wr_data are stable while sram_req=1 and !sram_ack.
  - sram_req deasserts the cycle after sram_ack.
  - An sram_rd_vld outside the RD*_WAIT states is ignored.
- Reset mid-operation: returns to IDLE immediately and drops sram_req. A pending read return after reset is ignored. The partial RMW is abandoned; no write is issued.

Optional Feature:
- Macro: BLOOM_SRAM_CTRL_STATS_EN.
- Defined:
  - stat_insert counts accepted inserts.
  - stat_hit and stat_miss count ACK outcomes.
  - stat_sat counts writes whose new value equals CNT_MAX.
  - All are 32-bit, wrap at 2^32, updated in DONE.
- Undefined: all stat_* outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- Package bloom_pkg:
  - state localparams, one-hot, 9 bits.
  - CNT_MAX derivation.
  - read/write encoding constants (RD=1, WR=0).
- Sub-module bloom_cnt_update (combinational): inputs c, is_ack; output new value and sat flag. It is instantiated twice, once per index.

Test Plan:
- Insert i0=0x00010, i1=0x00020 on zeroed SRAM, then ACK with the same indices:
  - After the insert, both words read 1.
  - The ACK gives lookup_vld with lookup_hit=1, and both words return to 0.
- ACK on empty SRAM at i0=0x00005, i1=0x7FFFF -> lookup_hit=0, no sram_rd_wr_L=0 cycle observed.
- Equal indices i0=i1=0x12345, insert twice -> exactly 2 reads and 2 writes total, final word=2.
- Saturation: preload word=0xF; insert, then ACK -> value stays 0xF, lookup_hit=1 when the partner counter is nonzero, stat_sat increments (STATS_EN).
- Arbiter backpressure: hold sram_ack low 5 cycles and delay sram_rd_vld 3 cycles -> address/data stable throughout, a bloom_wr issued while busy is dropped, final SRAM contents are correct.
- Reset asserted in RD1_WAIT, then a stale sram_rd_vld -> bloom_rdy=1 the cycle after reset, no write issued, the next request completes normally.
